uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver and next-generation RX path for the APB UART IP.
- Runtime-selectable word length, parity and stop bits; stop and parity checks are per word.
- Glitch-rejecting start detection.
- Built-in first-word-fall-through RX FIFO with a valid/ready pop handshake and a sticky overrun flag.
- Sits between the pad-side rx_serial line and the APB register block, which pops words and reads status.

Parameters:
DATA_W, 8, maximum data bits per word (legal 5..9); sets rx_data width
DIV_W, 16, width of baud_div
FIFO_DEPTH, 8, RX FIFO entries; power of 2, >= 2
LVL_W, $clog2(FIFO_DEPTH+1), width of rx_level

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_en  in  1  enables start-bit acceptance
baud_div  in  DIV_W  clk cycles per bit; legal >= 4
cfg_data_bits  in  4  data bits per word, 5..DATA_W; any other value is treated as DATA_W
cfg_parity_en  in  1  parity bit present
cfg_parity_odd  in  1  1 = odd parity, 0 = even parity
cfg_stop2  in  1  1 = two stop bits
rx_serial  in  1  asynchronous serial input, idle high
rx_data  out  DATA_W  FIFO head data, LSB = first received bit, unused MSBs 0
rx_parity_err  out  1  parity error flag of the head word
rx_frame_err  out  1  framing error flag of the head word
rx_valid  out  1  FIFO not empty
rx_ready  in  1  pop request; a pop occurs when rx_valid & rx_ready
rx_level  out  LVL_W  FIFO occupancy
rx_overrun  out  1  sticky: a word was dropped because the FIFO was full
clr_overrun  in  1  clears rx_overrun
rx_busy  out  1  frame in progress (state != IDLE)
rx_done_tick  out  1  one-cycle pulse per completed frame, whether pushed or dropped

Behaviour:
- All flops reset synchronously on rst. Reset values:
  - outputs: rx_valid=0, rx_level=0, rx_overrun=0, rx_busy=0, rx_done_tick=0; rx_data, rx_parity_err and rx_frame_err read 0 while empty.
  - synchroniser: 2'b11. FSM: IDLE. FIFO pointers: 0.
- A reset mid-frame aborts the frame and empties the FIFO.
- Synchroniser and edge detect:
  - rx_serial passes through 2 flops to give rxs.
  - A falling edge (previous rxs=1, current rxs=0) in IDLE with rx_en=1 starts a frame.
  - cfg_* and baud_div are latched at the edge and held for the whole frame.
- Baud counter (DIV_W bits, counts down):
  - tick = (cnt==0) while not IDLE.
  - On entry to START, load (baud_div>>1)-1. On every tick, reload baud_div-1.
  - Every sample is therefore taken at bit centre, one bit period apart.
- FSM:
  - IDLE -> START on an accepted edge.
  - START: on tick, rxs=0 -> DATA with bit_idx=0; rxs=1 -> IDLE (glitch; no push, no flags, no done tick).
  - DATA: on tick, shift rxs into bit bit_idx. After bit latched_bits-1 -> PARITY if parity enabled, else STOP1.
  - PARITY: on tick, perr = (XOR of data bits ^ rxs) != latched_odd. Next state is STOP1.
  - STOP1: on tick, ferr |= ~rxs. Then -> STOP2 if stop2, else complete.
  - STOP2: on tick, ferr |= ~rxs, then complete.
  - Complete: on the final stop-bit tick cycle, push {ferr, perr, data}, pulse rx_done_tick and go to IDLE. A new falling edge is accepted from the next cycle.
- rx_en deassertion mid-frame: the current frame completes normally; no new start is accepted.
- FIFO (FWFT):
  - Head outputs are valid combinationally from the storage read pointer. Data appears on rx_data one cycle after the push.
  - Push when full with no pop in the same cycle: the word is dropped and rx_overrun sets.
  - Push when full with a pop in the same cycle: the push is accepted and rx_level stays at FIFO_DEPTH.
  - Push and pop in the same cycle when not full: rx_level is unchanged.
  - Pop when empty: ignored.
  - Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally; full/empty is derived from rx_level.
- clr_overrun and a new overrun in the same cycle: the set wins.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each bit value, including the START check, is the 2-of-3 majority of rxs at cnt==2, cnt==1 and cnt==0 of the interval. Requires baud_div >= 8.
- Undefined: single sample of rxs at tick. No extra flops.

Test Plan:
- Basic frame: baud_div=16, 8N1, send 0xA5, rx_ready=0 -> rx_valid=1, rx_data=0xA5, rx_level=1, no error flags, exactly one rx_done_tick. Pop -> rx_valid=0.
- Parity error: 7 data bits, even parity, send 0x35 with its parity bit inverted -> rx_data=0x35, rx_parity_err=1, rx_frame_err=0.
- Framing error and two stop bits: 8E2, second stop bit driven 0 on word 0x3C -> rx_frame_err=1, rx_parity_err=0. Next frame 0x3C with correct stop bits -> both flags 0.
- Glitch rejection: rx_serial low for 4 cycles at baud_div=16 -> FSM returns to IDLE, rx_busy pulse only, no push, no rx_done_tick.
- Overrun: FIFO_DEPTH=4, send 5 words 0x01..0x05 with no pops -> rx_level=4, rx_overrun=1, pops return 0x01..0x04. clr_overrun -> rx_overrun=0.
- Boundary cases:
  - 5th word arriving with pop asserted on its push cycle -> accepted, no overrun.
  - Back-to-back frames with zero idle gap between them -> all received.
  - rst asserted mid-DATA -> rx_busy=0 and rx_level=0 next cycle.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with a first-word-fall-through RX FIFO.
// Word length, parity and stop bits are latched at each start edge and held for the whole frame.
// Optional feature macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority of the
// synchronised line at cnt==2, cnt==1 and cnt==0 (needs baud_div >= 8). When the macro is
// undefined, each bit is a single sample taken at the tick.
module uart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_en,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [3:0]        cfg_data_bits,
  input  logic              cfg_parity_en,
  input  logic              cfg_parity_odd,
  input  logic              cfg_stop2,
  input  logic              rx_serial,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [LVL_W-1:0]  rx_level,
  output logic              rx_overrun,
  input  logic              clr_overrun,
  output logic              rx_busy,
  output logic              rx_done_tick
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int WORD_W = DATA_W + 2;
  localparam logic [3:0]       MAX_BITS = 4'(DATA_W);
  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  // Line synchroniser and edge-detect history
  logic [1:0] sync_q;
  logic       rxs_prev_q;
  logic       rxs;
  logic       fall;

  // Receiver state
  state_t            state_q;
  logic [DIV_W-1:0]  cnt_q;
  logic [DIV_W-1:0]  div_q;
  logic [3:0]        bits_q;
  logic [3:0]        bit_idx_q;
  logic              par_en_q;
  logic              odd_q;
  logic              stop2_q;
  logic [DATA_W-1:0] data_q;
  logic              perr_q;
  logic              ferr_q;

  logic              tick;
  logic              sample;
  logic [3:0]        eff_bits;
  logic              frame_done;
  logic [WORD_W-1:0] push_word;

  // FIFO state
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q;
  logic [PTR_W-1:0]  rptr_q;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_d;
  logic              overrun_q;
  logic              full;
  logic              pop;
  logic              push_ok;
  logic [WORD_W-1:0] head_word;

  assign rxs  = sync_q[1];
  assign fall = rxs_prev_q & ~rxs;

  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= 2'b11;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[0], rx_serial};
      rxs_prev_q <= rxs;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  localparam logic [DIV_W-1:0] CNT_TWO = DIV_W'(2);
  logic early2_q;
  logic early1_q;

  // Capture the two early votes of the majority sample in each bit interval
  always_ff @(posedge clk) begin
    if (rst) begin
      early2_q <= 1'b1;
      early1_q <= 1'b1;
    end else begin
      if (cnt_q == CNT_TWO) early2_q <= rxs;
      if (cnt_q == CNT_ONE) early1_q <= rxs;
    end
  end

  assign sample = (early2_q & early1_q) | (early2_q & rxs) | (early1_q & rxs);
`else
  assign sample = rxs;
`endif

  assign tick       = (state_q != S_IDLE) && (cnt_q == '0);
  assign eff_bits   = ((cfg_data_bits >= 4'd5) && (cfg_data_bits <= MAX_BITS)) ? cfg_data_bits : MAX_BITS;
  assign frame_done = tick && (((state_q == S_STOP1) && !stop2_q) || (state_q == S_STOP2));
  assign push_word  = {ferr_q | ~sample, perr_q, data_q};

  // Frame FSM with its baud counter; config is frozen at the accepted start edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      bits_q    <= MAX_BITS;
      bit_idx_q <= '0;
      par_en_q  <= 1'b0;
      odd_q     <= 1'b0;
      stop2_q   <= 1'b0;
      data_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      if (state_q != S_IDLE) begin
        cnt_q <= tick ? (div_q - CNT_ONE) : (cnt_q - CNT_ONE);
      end
      case (state_q)
        S_IDLE: begin
          if (rx_en && fall) begin
            state_q   <= S_START;
            cnt_q     <= (baud_div >> 1) - CNT_ONE;
            div_q     <= baud_div;
            bits_q    <= eff_bits;
            par_en_q  <= cfg_parity_en;
            odd_q     <= cfg_parity_odd;
            stop2_q   <= cfg_stop2;
            bit_idx_q <= '0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
          end
        end
        S_START: begin
          if (tick) begin
            if (!sample) begin
              state_q   <= S_DATA;
              bit_idx_q <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            data_q <= data_q | (DATA_W'(sample) << bit_idx_q);
            if (bit_idx_q == (bits_q - 4'd1)) begin
              state_q <= par_en_q ? S_PARITY : S_STOP1;
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            perr_q  <= ((^data_q) ^ sample) != odd_q;
            state_q <= S_STOP1;
          end
        end
        S_STOP1: begin
          if (tick) begin
            ferr_q  <= ferr_q | ~sample;
            state_q <= stop2_q ? S_STOP2 : S_IDLE;
          end
        end
        S_STOP2: begin
          if (tick) begin
            ferr_q  <= ferr_q | ~sample;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_busy      = (state_q != S_IDLE);
  assign rx_done_tick = frame_done;

  assign full    = (level_q == FULL_LVL);
  assign rx_valid = (level_q != '0);
  assign pop     = rx_valid & rx_ready;
  assign push_ok = frame_done & (~full | pop);

  // Occupancy next-state: a simultaneous push and pop leaves the level unchanged
  always_comb begin
    level_d = level_q;
    if (push_ok && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (!push_ok && pop) begin
      level_d = level_q - LVL_ONE;
    end
  end

  // FIFO storage, pointers, occupancy and the sticky overrun flag (set beats clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= push_word;
        wptr_q        <= wptr_q + PTR_ONE;
      end
      if (pop) begin
        rptr_q <= rptr_q + PTR_ONE;
      end
      level_q <= level_d;
      if (frame_done && full && !pop) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign head_word     = mem_q[rptr_q];
  assign rx_data       = rx_valid ? head_word[DATA_W-1:0] : '0;
  assign rx_parity_err = rx_valid & head_word[DATA_W];
  assign rx_frame_err  = rx_valid & head_word[DATA_W+1];
  assign rx_level      = level_q;
  assign rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed and randomised frames against a queue-based model.
module tb_uart_rx_fifo;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_en;
  logic [DIV_W-1:0]  baud_div;
  logic [3:0]        cfg_data_bits;
  logic              cfg_parity_en;
  logic              cfg_parity_odd;
  logic              cfg_stop2;
  logic              rx_serial;
  logic [DATA_W-1:0] rx_data;
  logic              rx_parity_err;
  logic              rx_frame_err;
  logic              rx_valid;
  logic              rx_ready;
  logic [LVL_W-1:0]  rx_level;
  logic              rx_overrun;
  logic              clr_overrun;
  logic              rx_busy;
  logic              rx_done_tick;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  int doneCount  = 0;

  // Reference model: expected FIFO contents as {ferr, perr, data} and the overrun flag
  logic [9:0] expQ[$];
  bit         expOverrun = 1'b0;

  uart_rx_fifo #(
    .DATA_W(DATA_W),
    .DIV_W(DIV_W),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_en(rx_en),
    .baud_div(baud_div),
    .cfg_data_bits(cfg_data_bits),
    .cfg_parity_en(cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd),
    .cfg_stop2(cfg_stop2),
    .rx_serial(rx_serial),
    .rx_data(rx_data),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_level(rx_level),
    .rx_overrun(rx_overrun),
    .clr_overrun(clr_overrun),
    .rx_busy(rx_busy),
    .rx_done_tick(rx_done_tick)
  );

  always #5 clk = ~clk;

  // Count completed frames, sampled mid-cycle
  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) doneCount++;
  end

  // Hard time limit so the bench can never hang
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one frame on rx_serial (starting at a negedge) and return the word the receiver should produce
  task automatic applyStimulus(input logic [8:0] data, input logic [3:0] cfgBits, input bit parEn,
                               input bit odd, input bit stop2, input bit flipPar, input bit badStop1,
                               input bit badStop2, input int gap, output logic [9:0] expWord);
    int         nb;
    int         ones;
    int         period;
    logic [8:0] d;
    bit         parBit;
    bit         perr;
    bit         ferr;
    nb     = (cfgBits >= 4'd5 && cfgBits <= 4'd8) ? int'(cfgBits) : 8;
    period = int'(baud_div);
    d      = '0;
    for (int i = 0; i < nb; i++) d[i] = data[i];
    ones   = $countones(d);
    parBit = (odd ? (ones % 2 == 0) : (ones % 2 == 1)) ^ flipPar;
    perr   = parEn && (((ones + int'(parBit)) % 2 == 1) != odd);
    ferr   = badStop1 || (stop2 && badStop2);
    expWord = {ferr, perr, d[7:0]};

    cfg_data_bits  = cfgBits;
    cfg_parity_en  = parEn;
    cfg_parity_odd = odd;
    cfg_stop2      = stop2;
    rx_serial = 1'b0;
    repeat (period) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      rx_serial = d[i];
      repeat (period) @(negedge clk);
    end
    if (parEn) begin
      rx_serial = parBit;
      repeat (period) @(negedge clk);
    end
    rx_serial = ~badStop1;
    repeat (period) @(negedge clk);
    if (stop2) begin
      rx_serial = ~badStop2;
      repeat (period) @(negedge clk);
    end
    rx_serial = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic modelPush(input logic [9:0] w);
    if (expQ.size() < DEPTH) expQ.push_back(w);
    else expOverrun = 1'b1;
  endtask

  // Check the head word against the model, then pop it
  task automatic popAndCheck(input string tag);
    logic [9:0] w;
    if (expQ.size() == 0) begin
      checkOutput({tag, "_empty"}, rx_valid, 0);
      return;
    end
    w = expQ[0];
    checkOutput({tag, "_valid"}, rx_valid, 1);
    checkOutput({tag, "_data"}, rx_data, w[7:0]);
    checkOutput({tag, "_perr"}, rx_parity_err, w[8]);
    checkOutput({tag, "_ferr"}, rx_frame_err, w[9]);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    void'(expQ.pop_front());
  endtask

  initial begin
    logic [9:0] w;
    int         d0;
    bit         sawBusy;
    bit         got;
    int         divSel;
    int         bitsSel;
    logic [3:0] bitsTab [6];
    logic [DIV_W-1:0] divTab [4];

    bitsTab[0] = 4'd5; bitsTab[1] = 4'd6; bitsTab[2] = 4'd7;
    bitsTab[3] = 4'd8; bitsTab[4] = 4'd0; bitsTab[5] = 4'd12;
    divTab[0] = 16'd8; divTab[1] = 16'd10; divTab[2] = 16'd16; divTab[3] = 16'd23;

    rst = 1'b1; rx_en = 1'b1; baud_div = 16'd16; cfg_data_bits = 4'd8;
    cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
    rx_serial = 1'b1; rx_ready = 1'b0; clr_overrun = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_valid", rx_valid, 0);
    checkOutput("rst_level", rx_level, 0);
    checkOutput("rst_overrun", rx_overrun, 0);
    checkOutput("rst_busy", rx_busy, 0);
    checkOutput("rst_done", rx_done_tick, 0);
    checkOutput("rst_data", rx_data, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] basic 8N1 frame");
    d0 = doneCount;
    applyStimulus(9'h0A5, 4'd8, 0, 0, 0, 0, 0, 0, 4, w);
    modelPush(w);
    checkOutput("basic_level", rx_level, expQ.size());
    checkOutput("basic_data_const", rx_data, 8'hA5);
    checkOutput("basic_done_count", doneCount - d0, 1);
    popAndCheck("basic");
    checkOutput("basic_after_pop_valid", rx_valid, 0);

    $display("[TB] parity error, 7E1");
    applyStimulus(9'h035, 4'd7, 1, 0, 0, 1, 0, 0, 4, w);
    modelPush(w);
    checkOutput("par_perr_const", rx_parity_err, 1);
    popAndCheck("par");

    $display("[TB] framing error, 8E2");
    applyStimulus(9'h03C, 4'd8, 1, 0, 1, 0, 0, 1, 4, w);
    modelPush(w);
    checkOutput("frm_ferr_const", rx_frame_err, 1);
    popAndCheck("frm_bad");
    applyStimulus(9'h03C, 4'd8, 1, 0, 1, 0, 0, 0, 4, w);
    modelPush(w);
    popAndCheck("frm_good");

    $display("[TB] glitch rejection");
    d0 = doneCount;
    sawBusy = 1'b0;
    rx_serial = 1'b0;
    repeat (4) @(negedge clk);
    rx_serial = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rx_busy) sawBusy = 1'b1;
    end
    checkOutput("glitch_saw_busy", sawBusy, 1);
    checkOutput("glitch_busy_end", rx_busy, 0);
    checkOutput("glitch_level", rx_level, 0);
    checkOutput("glitch_done", doneCount - d0, 0);

    $display("[TB] overrun");
    d0 = doneCount;
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(9'(k), 4'd8, 0, 0, 0, 0, 0, 0, 4, w);
      modelPush(w);
    end
    checkOutput("ovr_level", rx_level, expQ.size());
    checkOutput("ovr_flag", rx_overrun, expOverrun);
    checkOutput("ovr_done", doneCount - d0, 5);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    expOverrun = 1'b0;
    checkOutput("ovr_cleared", rx_overrun, expOverrun);
    for (int k = 0; k < 4; k++) popAndCheck("ovr_pop");
    checkOutput("ovr_empty", rx_valid, 0);

    $display("[TB] push into full FIFO with same-cycle pop");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(9'h011 + 9'(k), 4'd8, 0, 0, 0, 0, 0, 0, 4, w);
      modelPush(w);
    end
    got = 1'b0;
    fork
      applyStimulus(9'h015, 4'd8, 0, 0, 0, 0, 0, 0, 4, w);
      begin
        for (int i = 0; i < 3000 && !got; i++) begin
          @(negedge clk);
          if (rx_done_tick === 1'b1) begin
            got = 1'b1;
            checkOutput("pp_head", rx_data, expQ[0][7:0]);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
          end
        end
      end
    join
    checkOutput("pp_seen_done", got, 1);
    void'(expQ.pop_front());
    modelPush(w);
    checkOutput("pp_level", rx_level, expQ.size());
    checkOutput("pp_overrun", rx_overrun, expOverrun);
    for (int k = 0; k < 4; k++) popAndCheck("pp_pop");

    $display("[TB] back-to-back frames");
    applyStimulus(9'h05A, 4'd8, 0, 0, 0, 0, 0, 0, 0, w);
    modelPush(w);
    applyStimulus(9'h0C3, 4'd8, 0, 0, 0, 0, 0, 0, 0, w);
    modelPush(w);
    applyStimulus(9'h07E, 4'd8, 0, 0, 0, 0, 0, 0, 4, w);
    modelPush(w);
    checkOutput("b2b_level", rx_level, expQ.size());
    for (int k = 0; k < 3; k++) popAndCheck("b2b_pop");

    $display("[TB] rx_en dropped mid-frame");
    fork
      applyStimulus(9'h06D, 4'd8, 0, 0, 0, 0, 0, 0, 4, w);
      begin
        repeat (40) @(negedge clk);
        rx_en = 1'b0;
      end
    join
    modelPush(w);
    checkOutput("en_level", rx_level, expQ.size());
    popAndCheck("en_pop");
    d0 = doneCount;
    applyStimulus(9'h099, 4'd8, 0, 0, 0, 0, 0, 0, 4, w);
    checkOutput("en_off_level", rx_level, 0);
    checkOutput("en_off_done", doneCount - d0, 0);
    rx_en = 1'b1;

    $display("[TB] randomised frames");
    for (int k = 0; k < 12; k++) begin
      divSel  = $urandom_range(0, 3);
      bitsSel = $urandom_range(0, 5);
      baud_div = divTab[divSel];
      applyStimulus(9'($urandom), bitsTab[bitsSel], 1'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 4) == 0), 4, w);
      modelPush(w);
      checkOutput("rnd_level", rx_level, expQ.size());
      popAndCheck("rnd");
    end
    baud_div = 16'd16;

    $display("[TB] reset mid-frame");
    applyStimulus(9'h042, 4'd8, 0, 0, 0, 0, 0, 0, 4, w);
    modelPush(w);
    cfg_data_bits = 4'd8; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
    rx_serial = 1'b0;
    repeat (16) @(negedge clk);
    rx_serial = 1'b1;
    repeat (16) @(negedge clk);
    rx_serial = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("rstmid_busy_before", rx_busy, 1);
    checkOutput("rstmid_level_before", rx_level, expQ.size());
    rst = 1'b1;
    @(negedge clk);
    expQ.delete();
    expOverrun = 1'b0;
    checkOutput("rstmid_busy", rx_busy, 0);
    checkOutput("rstmid_level", rx_level, 0);
    rst = 1'b0;
    rx_serial = 1'b1;
    repeat (40) @(negedge clk);
    applyStimulus(9'h0E7, 4'd8, 0, 0, 0, 0, 0, 0, 4, w);
    modelPush(w);
    popAndCheck("rstmid_recover");

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
